button_request_latch: RTL and testbench

BUTTON_REQUEST_LATCH -- requirements
Module: button_request_latch

---
 rtl/button_request_latch.sv | 120 ++++++++++++
 tb/tb_button_request_latch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_request_latch.sv
// Pushbutton debouncer with press pulse, saturating press counter and a two-state extend-request latch.
// Build option: define REQ_HOLD_TIMEOUT_EN to let a latched request expire after HOLD_CYCLES.
module button_request_latch #(
  parameter logic [31:0] DEB_CYCLES  = 32'd1000000,
  parameter logic [31:0] HOLD_CYCLES = 32'd600000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       clr,
  output logic       stable,
  output logic       press,
  output logic       req,
  output logic [7:0] press_cnt
);

  typedef enum logic {StIdle, StHeld} state_t;

  // A zero debounce length is treated as one cycle of mismatch.
  localparam logic [31:0] DebLast = (DEB_CYCLES == 32'd0) ? 32'd0 : DEB_CYCLES - 32'd1;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic [31:0] r_deb_cnt;
  logic        r_press;
  logic [7:0]  r_press_cnt;
  state_t      r_state;
  state_t      w_state_d;
  logic        w_mismatch;
  logic        w_accept;
  logic        w_rise;
  logic        w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mismatch = (r_sync2 != r_stable);
  assign w_accept   = w_mismatch && (r_deb_cnt == DebLast);
  assign w_rise     = w_accept && !r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_cnt <= 32'd0;
      r_stable  <= 1'b0;
    end else if (!w_mismatch || w_accept) begin
      r_deb_cnt <= 32'd0;
      r_stable  <= r_stable ^ w_accept;
    end else begin
      r_deb_cnt <= r_deb_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_press     <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      r_press <= w_rise;
      if (w_rise && (r_press_cnt != 8'd255)) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
    end
  end

`ifdef REQ_HOLD_TIMEOUT_EN
  localparam logic [31:0] HoldLast = (HOLD_CYCLES == 32'd0) ? 32'd0 : HOLD_CYCLES - 32'd1;

  logic [31:0] r_hold_cnt;

  // Held at zero while idle, so it starts from zero on every entry to HELD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= 32'd0;
    end else if (r_state == StIdle) begin
      r_hold_cnt <= 32'd0;
    end else begin
      r_hold_cnt <= r_hold_cnt + 32'd1;
    end
  end

  assign w_timeout = (r_state == StHeld) && (r_hold_cnt == HoldLast);
`else
  assign w_timeout = 1'b0;

  // HOLD_CYCLES only matters in the timeout build; this empty block just references it.
  if (HOLD_CYCLES == 32'd0) begin : g_hold_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (r_press && !clr) w_state_d = StHeld;
      StHeld: if (clr || w_timeout) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign stable    = r_stable;
  assign press     = r_press;
  assign req       = (r_state == StHeld);
  assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_button_request_latch.sv
// Self-checking bench for button_request_latch: directed steps plus random bouncing input,
// compared against a window-based behavioural model.
module tb_button_request_latch;

  localparam logic [31:0] Deb  = 32'd4;
  localparam logic [31:0] Hold = 32'd10;
  localparam int N = (Deb == 0) ? 1 : int'(Deb);
`ifdef REQ_HOLD_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       btn;
  logic       clr;
  logic       stable;
  logic       press;
  logic       req;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  bit m_s1, m_s2, m_stable, m_press, m_req;
  int m_cnt, m_enter, cyc;
  bit hist[$];

  button_request_latch #(
    .DEB_CYCLES (Deb),
    .HOLD_CYCLES(Hold)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .clr      (clr),
    .stable   (stable),
    .press    (press),
    .req      (req),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_stable = 0; m_press = 0; m_req = 0;
    m_cnt = 0; m_enter = 0;
    hist.delete();
  endtask

  // stable flips once the last N synchronized samples all disagree with it.
  task automatic model_step();
    bit s2_old, press_old, all_diff;
    s2_old    = m_s2;
    press_old = m_press;
    cyc++;
    hist.push_back(s2_old);
    if (hist.size() > N) void'(hist.pop_front());
    all_diff = (hist.size() == N);
    foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
    if (all_diff) hist.delete();
    m_press  = all_diff && !m_stable;
    m_stable = m_stable ^ all_diff;
    if (m_press && m_cnt < 255) m_cnt++;
    if (m_req) begin
      if (clr || (TimeoutEn && (cyc - m_enter >= int'(Hold)))) m_req = 0;
    end else if (press_old && !clr) begin
      m_req   = 1;
      m_enter = cyc;
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stable"}, stable, m_stable);
    check({tag, ".press"}, press, m_press);
    check({tag, ".req"}, req, m_req);
    check({tag, ".cnt"}, press_cnt, m_cnt);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  // Hold btn high until the model predicts the press pulse; ends at the negedge showing it.
  task automatic press_button(input string tag);
    int n = 0;
    btn = 1'b1;
    do begin
      tick(tag);
      n++;
    end while (!m_press && n < 20);
    check({tag, ".press_seen"}, press, 1'b1);
  endtask

  initial begin
    int hi_cnt;
    int cnt_before;
    rst = 1'b1; btn = 1'b0; clr = 1'b0;
    cyc = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Short bounces never reach the debounce length.
    btn = 1'b1; repeat (3) tick("bounce");
    btn = 1'b0; tick("bounce");
    btn = 1'b1; repeat (3) tick("bounce");
    btn = 1'b0; repeat (8) tick("bounce");
    check("bounce_stable", stable, 1'b0);
    check("bounce_cnt", press_cnt, 8'd0);

    // Clean press: stable/press exactly 2+4 edges after btn rises, req one edge later.
    btn = 1'b1;
    repeat (5) tick("rise");
    check("rise_no_early_press", press, 1'b0);
    tick("rise");
    check("rise_press_at_6", press, 1'b1);
    check("rise_stable_at_6", stable, 1'b1);
    check("rise_cnt", press_cnt, 8'd1);
    tick("rise");
    check("rise_req", req, 1'b1);
    check("rise_press_one_cycle", press, 1'b0);
    clr = 1'b1; tick("clr");
    clr = 1'b0;
    check("clr_req_low", req, 1'b0);

    // Second press while HELD, coincident with clr.
    btn = 1'b0; repeat (8) tick("rel");
    press_button("p2");
    btn = 1'b0; repeat (4) tick("p2_low");
    press_button("p3");
    check("coinc_req_before", req, 1'b1);
    cnt_before = m_cnt;
    clr = 1'b1; tick("coinc");
    clr = 1'b0;
    check("coinc_req_low", req, 1'b0);
    check("coinc_cnt", press_cnt, 8'(cnt_before));
    btn = 1'b0; repeat (8) tick("rel2");

    // Hold duration with no clr.
    press_button("hold");
    btn = 1'b0;
    hi_cnt = 0;
    repeat (1000) begin
      tick("hold");
      if (req) hi_cnt++;
    end
    if (TimeoutEn) begin
      check("hold_timeout_len", hi_cnt, 10);
    end else begin
      check("hold_no_timeout_len", hi_cnt, 1000);
      check("hold_still_req", req, 1'b1);
    end
    clr = 1'b1; tick("hold_clr");
    clr = 1'b0;
    check("hold_clr_req", req, 1'b0);

    // Random bouncy input with occasional clr.
    repeat (200) begin
      btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) begin
        clr = ($urandom_range(0, 15) == 0);
        tick("rand");
      end
    end
    clr = 1'b0; btn = 1'b0; repeat (8) tick("rand_end");

    // Saturation of the press counter.
    clr = 1'b1;
    repeat (300) begin
      btn = 1'b1; repeat (6) tick("sat");
      btn = 1'b0; repeat (6) tick("sat");
    end
    clr = 1'b0;
    check("sat_cnt", press_cnt, 8'd255);

    // Reset while HELD.
    press_button("rst_held");
    btn = 1'b0;
    repeat (3) tick("rst_held");
    check("rst_held_req_before", req, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_imm_stable", stable, 1'b0);
    check("rst_imm_press", press, 1'b0);
    check("rst_imm_req", req, 1'b0);
    check("rst_imm_cnt", press_cnt, 8'd0);
    tick("rst_hold");
    rst = 1'b0;
    repeat (20) tick("post_rst");
    check("post_rst_no_press_cnt", press_cnt, 8'd0);

    // Reset mid-debounce abandons the pending edge.
    btn = 1'b1; repeat (4) tick("mid_deb");
    rst = 1'b1; #1; model_reset();
    tick("mid_deb_rst");
    rst = 1'b0; btn = 1'b0;
    repeat (10) tick("mid_deb_post");
    check("mid_deb_stable", stable, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
